// File: rtl/irq_pending.sv
// Sticky 8-source request capture with a one-entry valid/ready output slot.
// Source 0 has the highest priority; overruns on an already-pending source are flagged.
module irq_pending #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [7:0] i,
  input  logic [7:0] mask,
  output logic [2:0] y,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pend,
  output logic [7:0] ovf,
  input  logic       ovf_clr
);

  logic [7:0] i_d_q,   i_d_d;
  logic [7:0] pend_q,  pend_d;
  logic [7:0] ovf_q,   ovf_d;
  logic [2:0] y_q,     y_d;
  logic       valid_q, valid_d;

  logic [7:0] req;
  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] ovf_set;
  logic [2:0] sel_idx;
  logic       slot_free;
  logic       load;

  // Index of the lowest set bit; scanning downward lets the lowest index win.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) lowest_idx = 3'(k);
    end
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'd1 << idx;
  endfunction

  always_comb begin
    i_d_d     = i;
    req       = EDGE ? (i & ~i_d_q) : i;
    set       = req & mask & {8{e}};

    // Loads look only at the registered pend, so a fresh capture waits a cycle.
    slot_free = ~valid_q | ready;
    load      = e & slot_free & (|pend_q);
    sel_idx   = lowest_idx(pend_q);
    clr       = load ? onehot8(sel_idx) : 8'd0;

    // Set after clear so a request arriving on the bit being issued is kept.
    pend_d    = (pend_q & ~clr) | set;

    ovf_set   = set & pend_q & ~clr;
    ovf_d     = (ovf_q & ~{8{ovf_clr}}) | ovf_set;

    y_d       = y_q;
    valid_d   = valid_q;
    if (load) begin
      y_d     = sel_idx;
      valid_d = 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_d_q   <= 8'd0;
      pend_q  <= 8'd0;
      ovf_q   <= 8'd0;
      y_q     <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      i_d_q   <= i_d_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

endmodule
